// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame geometry and
// default 50 MHz timing constants.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_CLK  = 3'd3,
        ST_SHIFT     = 3'd4,
        ST_ACK       = 3'd5,
        ST_LINE_IDLE = 3'd6
    } ps2_state_e;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_ACK_EDGE   = 11;
    localparam int PS2_SHIFT_BITS = 10;

    localparam int PS2_INHIBIT_CYCLES_50M = 5000;
    localparam int PS2_TIMEOUT_CYCLES_50M = 1_000_000;

    // Host-side shift frame, LSB first: data[7:0], odd parity, stop.
    function automatic logic [PS2_SHIFT_BITS-1:0] ps2_build_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a falling-edge
// detector on the synchronized clock; shared with the scan receiver.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_s,
    output logic data_s,
    output logic fall
);

    logic [1:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;
    logic       clk_prev_q, clk_prev_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        clk_prev_d  = clk_sync_q[1];
    end

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard
// through active-high pull-low enables and waits for the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_50M,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_50M
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2k_clk,
    input  logic       ps2k_data,
    output logic       ps2k_clk_oe,
    output logic       ps2k_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] dbg_state
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    // Handshake: a byte is taken on any cycle where tx_valid and tx_ready are
    // both high; tx_ready is high only in IDLE, so tx_valid is ignored otherwise.

    logic clk_s, data_s, fall;

    ps2_line_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2k_clk),
        .ps2_data_in (ps2k_data),
        .clk_s       (clk_s),
        .data_s      (data_s),
        .fall        (fall)
    );

    ps2_state_e                state_q, state_d;
    logic [INH_W-1:0]          inh_cnt_q, inh_cnt_d;
    logic [WD_W-1:0]           wd_cnt_q, wd_cnt_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [PS2_SHIFT_BITS-1:0] shift_q, shift_d;
    logic                      clk_oe_q, clk_oe_d;
    logic                      data_oe_q, data_oe_d;
    logic                      tx_ready_q, tx_ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic accept;
    logic wd_active;
    logic wd_expire;

    assign accept    = tx_valid & tx_ready_q;
    assign wd_active = state_q inside {ST_START, ST_WAIT_CLK, ST_SHIFT, ST_ACK, ST_LINE_IDLE};
    assign wd_expire = wd_active && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        wd_cnt_d  = wd_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (wd_active) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                if (accept) begin
                    state_d   = ST_INHIBIT;
                    shift_d   = ps2_build_frame(tx_data);
                    bit_cnt_d = 4'd0;
                    inh_cnt_d = '0;
                end
            end
            ST_INHIBIT: begin
                data_oe_d = 1'b0;
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_d   = ST_START;
                    wd_cnt_d  = '0;
                    data_oe_d = 1'b1;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            ST_START: begin
                // Start bit stays low while the clock is handed back to the device.
                data_oe_d = 1'b1;
                state_d   = ST_WAIT_CLK;
            end
            ST_WAIT_CLK, ST_SHIFT: begin
                if (fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[PS2_SHIFT_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (state_q == ST_WAIT_CLK) begin
                        state_d = ST_SHIFT;
                    end else if (bit_cnt_q == 4'(PS2_FRAME_BITS - 2)) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                data_oe_d = 1'b0;
                if (fall) begin
                    bit_cnt_d = 4'(PS2_ACK_EDGE);
                    if (data_s) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LINE_IDLE;
                    end
                end
            end
            ST_LINE_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                data_oe_d = 1'b0;
            end
        endcase

        // Watchdog wins over everything, including an ACK on the same cycle.
        if (wd_expire) begin
            state_d   = ST_IDLE;
            err_d     = 1'b1;
            done_d    = 1'b0;
            data_oe_d = 1'b0;
        end

        clk_oe_d   = (state_d == ST_INHIBIT) || (state_d == ST_START);
        tx_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            inh_cnt_q  <= '0;
            wd_cnt_q   <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inh_cnt_q  <= inh_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ps2k_clk_oe  = clk_oe_q;
    assign ps2k_data_oe = data_oe_q;
    assign tx_ready     = tx_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the piano controller to the attached PS/2 keyboard. It sits beside the existing PS/2 scan receiver on the same two open-drain lines and drives them only through active-high pull-low enables. It raises `busy` so the receiver path ignores line activity while a frame is going out.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-line inhibit time in `clk` cycles (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 1_000_000: whole-transaction watchdog in `clk` cycles (20 ms at 50 MHz).

- `clk`  in  1  50 MHz system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  command byte; sampled on accept.
- `tx_valid`  in  1  request to send.
- `tx_ready`  out  1  high only in IDLE; accept occurs when `tx_valid & tx_ready`.
- `ps2k_clk`  in  1  raw PS/2 clock pin level.
- `ps2k_data`  in  1  raw PS/2 data pin level.
- `ps2k_clk_oe`  out  1  1 = pull clock low, 0 = release.
- `ps2k_data_oe`  out  1  1 = pull data low, 0 = release.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: frame sent and ACK received.
- `err`  out  1  one-cycle pulse: NACK or timeout.

## Operation
- Both pins pass through a 2-flop synchronizer followed by a falling-edge detector on the synchronized clock (`fall`).
- On accept:
  - Latch `tx_data`.
  - Compute odd parity as `~^tx_data`.
  - Build the 10-bit shift frame {stop=1, parity, data[7:0]}.
- States and transitions:
  - IDLE: both enables 0. Accept → INHIBIT.
  - INHIBIT: `clk_oe`=1. Stay exactly `INHIBIT_CYCLES` cycles → START.
  - START: `clk_oe`=1 and `data_oe`=1 (start bit 0) for 1 cycle → WAIT_CLK. The watchdog starts at 0 here.
  - WAIT_CLK: `clk_oe`=0, `data_oe`=1. On the 1st `fall`, present data bit 0 → SHIFT.
  - SHIFT: each `fall` presents the next frame bit, with `data_oe = ~bit`. Falls 2–8 present data bits 1–7, fall 9 presents parity, fall 10 presents stop (data released). After fall 10 → ACK.
  - ACK: on `fall` 11, sample synchronized data. If data = 0 → LINE_IDLE. If data = 1 → `err` pulse → IDLE.
  - LINE_IDLE: wait until synchronized clock and data are both 1 → `done` pulse → IDLE.
- Watchdog:
  - Counts in START through LINE_IDLE.
  - When it reaches `TIMEOUT_CYCLES`: `err` pulse, both enables 0, → IDLE, regardless of state.
- `fall` events in IDLE, INHIBIT and START are ignored. This covers the self-induced edge created by pulling the clock line low.
- Bit counter is 4 bits and counts 0–11. It is cleared on accept.

## Timing
- Reset values: `ps2k_clk_oe`=0, `ps2k_data_oe`=0, `tx_ready`=1, `busy`=0, `done`=0, `err`=0. State = IDLE, all counters 0.
- Reset asserted mid-frame releases both lines asynchronously, in the same instant.
- All outputs are registered.
- `clk_oe` rises on the cycle after accept.
- `tx_ready` falls on the cycle after accept.
- A data-line update follows the pin falling edge by 3–4 `clk` cycles (synchronizer + edge detect + register). This is far inside the device's ≥15 µs clock-low time.
- `tx_valid` is ignored while `tx_ready`=0, and a new `tx_data` value does not corrupt the frame in flight. A new accept is possible on the cycle after the `done`/`err` pulse.
- `done` and `err` are never high together.
- A watchdog expiry on the same cycle as fall 11 counts as a timeout: `err` is raised, `done` is not.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum;
  - frame constants: `PS2_FRAME_BITS`=11, `PS2_ACK_EDGE`=11;
  - default cycle constants for 50 MHz.
- Sub-module `ps2_line_sync` contains the 2-flop synchronizers and the clock falling-edge detector. It is reusable by the receiver.
- Top-level integration drives each pin as `oe ? 1'b0 : 1'bz`.

## Test plan
1. Send 0xED with a device model that clocks 11 edges and ACKs:
   - `clk_oe` is high for 5000 cycles.
   - Data bits on falls 1–10 are 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - `done` pulses once; `err` stays 0.
2. Send 0x01:
   - Parity bit is 0.
   - Send 0xFF: parity bit is 1.
   - Both frames complete with `done`.
3. Send with the device holding data high at fall 11 (NACK):
   - `err` pulses on the cycle after fall 11 is detected.
   - `done` stays 0; `tx_ready` returns to 1.
4. Send with a silent device (no clock edges):
   - `err` pulses `TIMEOUT_CYCLES` after START.
   - Both enables go to 0.
5. Assert `rst` during data bit 4:
   - Both enables go to 0 and state returns to IDLE immediately.
   - After reset is released, `tx_ready`=1 and a fresh 0xF4 completes normally.
6. Hold `tx_valid` with 0xAA while the 0xED frame is in flight:
   - The wire shows 0xED only.
   - 0xAA is accepted on the cycle after `done` and sent with parity 1.
